// File: rtl/fir_tap_scheduler.sv
// -----------------------------------------------------------------------------
// fir_tap_scheduler
//   Folded FIR controller. One multiply-accumulate datapath is stepped over N
//   taps for each accepted sample. The block keeps a circular history of the
//   last N samples and a coefficient table that the host can write.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
//   in_ready depends only on internal state and coef_we, never on in_valid.
//   After acceptance, in_valid/in_sample are ignored until in_ready returns.
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         synchronous reset, active-high
//   in_valid    in_sample is valid
//   in_ready    block can accept a sample this cycle
//   in_sample   signed input sample (DW)
//   coef_we     coefficient write strobe
//   coef_addr   coefficient tap index 0..N-1 (AW)
//   coef_data   signed Q1.14 coefficient (CW)
//   coef_err    one-cycle pulse: previous coefficient write was rejected
//   out_valid   one-cycle pulse: out_sample carries a new result
//   out_sample  signed saturated filter output (OW), held between results
//   busy        high while the MAC sequence or output stage is running
//   state_dbg   current FSM state (debug observation)
// -----------------------------------------------------------------------------
module fir_tap_scheduler #(
    parameter int N     = 123,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int SHIFT = 14,
    parameter int OW    = 17,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          coef_err,
    output logic          out_valid,
    output logic [OW-1:0] out_sample,
    output logic          busy,
    output logic [1:0]    state_dbg
);

    localparam int ACC_W = 32;

    // Extended by one bit so that N == 2**AW still compares correctly.
    localparam logic [AW:0]               N_EXT   = (AW+1)'(N);
    localparam logic [AW-1:0]             IDX_MAX = AW'(N-1);
    localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'((2**(OW-1)) - 1);
    localparam logic signed [ACC_W-1:0]   SAT_MIN = ACC_W'(-(2**(OW-1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DW-1:0]    hist [N];
    logic signed [CW-1:0]    coef [N];
    logic [AW-1:0]           wp;
    logic [AW-1:0]           rp;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;

    logic                    handshake;
    logic                    coef_addr_ok;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACC_W-1:0] term;
    logic [OW-1:0]           sat_val;

    // A pending coefficient write wins over an incoming sample in IDLE.
    assign in_ready     = (state == IDLE) && !coef_we;
    assign handshake    = in_valid && in_ready;
    assign busy         = (state == MAC) || (state == DONE);
    assign state_dbg    = state;
    assign coef_addr_ok = ({1'b0, coef_addr} < N_EXT);

    // rp walks backwards from the newest sample, so tap k meets x[n-k].
    // Each product is floor-shifted on its own before accumulation.
    assign prod = hist[rp] * coef[k];
    assign term = ACC_W'(prod >>> SHIFT);

    always_comb begin
        sat_val = acc[OW-1:0];
        if (acc > SAT_MAX) begin
            sat_val = SAT_MAX[OW-1:0];
        end else if (acc < SAT_MIN) begin
            sat_val = SAT_MIN[OW-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (k == IDX_MAX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, history and coefficient storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            k          <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            coef_err   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
                coef[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            coef_err  <= 1'b0;

            // Writes are only safe while no MAC sequence reads the table.
            if (coef_we) begin
                if ((state == IDLE) && coef_addr_ok) begin
                    coef[coef_addr] <= coef_data;
                end else begin
                    coef_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        hist[wp] <= in_sample;
                        k        <= '0;
                        rp       <= wp;
                        acc      <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + term;
                    k   <= k + 1'b1;
                    rp  <= (rp == '0) ? IDX_MAX : rp - 1'b1;
                end
                DONE: begin
                    out_sample <= sat_val;
                    out_valid  <= 1'b1;
                    wp         <= (wp == IDX_MAX) ? '0 : wp + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fir_tap_scheduler
//   Self-checking bench for fir_tap_scheduler. Expected outputs come from
//   constant vectors and from a reference model that evaluates the FIR sum
//   directly: out[n] = sat(sum_k floor(coef[k]*x[n-k] / 2^14)).
// -----------------------------------------------------------------------------
module tb_fir_tap_scheduler;

    localparam int N     = 123;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int SHIFT = 14;
    localparam int OW    = 17;
    localparam int AW    = 7;

    // -------------------------------------------------------------------------
    // Clock / reset and DUT
    // -------------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sample;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          coef_err;
    logic          out_valid;
    logic [OW-1:0] out_sample;
    logic          busy;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    fir_tap_scheduler #(
        .N(N), .DW(DW), .CW(CW), .SHIFT(SHIFT), .OW(OW), .AW(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_err   (coef_err),
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // -------------------------------------------------------------------------
    // Scoreboard counters
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: coefficient table plus newest-first sample list
    // -------------------------------------------------------------------------
    int mcoef [N];
    int mhist [$];

    function automatic void model_reset();
        foreach (mcoef[i]) mcoef[i] = 0;
        mhist.delete();
    endfunction

    function automatic longint floor_div(input longint p, input longint d);
        longint q;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_push(input int x);
        longint sum;
        longint xs;
        mhist.push_front(x);
        if (mhist.size() > N) void'(mhist.pop_back());
        sum = 0;
        for (int t = 0; t < N; t++) begin
            xs  = (t < mhist.size()) ? longint'(mhist[t]) : 64'sd0;
            sum = sum + floor_div(xs * longint'(mcoef[t]), longint'(2 ** SHIFT));
        end
        if (sum > longint'((2 ** (OW-1)) - 1)) sum = longint'((2 ** (OW-1)) - 1);
        if (sum < -longint'(2 ** (OW-1)))      sum = -longint'(2 ** (OW-1));
        return int'(sum);
    endfunction

    // -------------------------------------------------------------------------
    // Driver tasks (drive after negedge, sample #1 after posedge)
    // -------------------------------------------------------------------------
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int addr, input int data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = addr[AW-1:0];
        coef_data = data[CW-1:0];
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (addr < N) mcoef[addr] = data;
    endtask

    task automatic accept(input int x);
        int guard;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = x[DW-1:0];
        guard     = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_sample = DW'($urandom);
    endtask

    task automatic wait_out(output int y, output int lat);
        lat = 0;
        y   = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 300);
        if (!out_valid) check("out_valid timeout", 0, 1);
        else            y = int'($signed(out_sample));
    endtask

    task automatic send_check(input int x, input string name, output int y);
        int exp;
        int lat;
        accept(x);
        exp = model_push(x);
        wait_out(y, lat);
        check({name, " model"}, y, exp);
        check({name, " latency"}, lat, N + 1);
    endtask

    // -------------------------------------------------------------------------
    // Vector table: single nonzero tap, impulse followed by zeros
    // -------------------------------------------------------------------------
    typedef struct {
        int tap;
        int cval;
        int x;
        int exp_out;
    } vec_t;

    vec_t vecs [8];

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int y;
        int lat;
        int exp;
        int seen;
        int xr;

        vecs[0] = '{tap: 0, cval: 16384,  x: 1000,   exp_out: 1000};
        vecs[1] = '{tap: 3, cval: 16384,  x: 500,    exp_out: 500};
        vecs[2] = '{tap: 0, cval: 8192,   x: -3,     exp_out: -2};
        vecs[3] = '{tap: 0, cval: 8192,   x: 3,      exp_out: 1};
        vecs[4] = '{tap: 5, cval: -16384, x: 1234,   exp_out: -1234};
        vecs[5] = '{tap: 1, cval: 16383,  x: -1,     exp_out: -1};
        vecs[6] = '{tap: 2, cval: 12345,  x: 0,      exp_out: 0};
        vecs[7] = '{tap: 4, cval: -16384, x: -32768, exp_out: 32768};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid",  int'(out_valid), 0);
        check("reset out_sample", int'($signed(out_sample)), 0);
        check("reset coef_err",   int'(coef_err), 0);
        check("reset busy",       int'(busy), 0);
        check("reset in_ready",   int'(in_ready), 1);
        check("reset state",      int'(state_dbg), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single-tap vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            write_coef(vecs[v].tap, vecs[v].cval);
            for (int i = 0; i <= vecs[v].tap; i++) begin
                send_check((i == 0) ? vecs[v].x : 0, $sformatf("vec%0d step%0d", v, i), y);
                exp = (i == vecs[v].tap) ? vecs[v].exp_out : 0;
                check($sformatf("vec%0d step%0d const", v, i), y, exp);
            end
        end

        // Output cycle: in_ready already back, busy low, pulse lasts one cycle
        do_reset();
        write_coef(0, 16384);
        accept(1000);
        void'(model_push(1000));
        wait_out(y, lat);
        check("t1 latency", lat, 124);
        check("t1 out", y, 1000);
        check("t1 in_ready at out_valid", int'(in_ready), 1);
        check("t1 busy at out_valid", int'(busy), 0);
        @(posedge clk);
        #1;
        check("t1 out_valid pulse", int'(out_valid), 0);
        check("t1 out_sample held", int'($signed(out_sample)), 1000);

        // Wrap of history pointers through the last tap
        do_reset();
        write_coef(122, 16384);
        for (int i = 0; i < 200; i++) begin
            send_check(i + 1, $sformatf("wrap %0d", i), y);
            check($sformatf("wrap %0d const", i), y, (i >= 122) ? (i - 121) : 0);
        end

        // Saturation in both directions
        do_reset();
        for (int t = 0; t < N; t++) write_coef(t, 16384);
        for (int i = 0; i < N; i++) send_check(32767, $sformatf("satp %0d", i), y);
        check("sat positive", y, 65535);
        for (int i = 0; i < N; i++) send_check(-32768, $sformatf("satn %0d", i), y);
        check("sat negative", y, -65536);

        // Coefficient write during MAC is rejected
        do_reset();
        write_coef(0, 16384);
        accept(777);
        exp = model_push(777);
        repeat (10) @(posedge clk);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 7'd0;
        coef_data = 16'd5000;
        check("in_ready during MAC", int'(in_ready), 0);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("coef_err during MAC", int'(coef_err), 1);
        check("busy during MAC", int'(busy), 1);
        @(posedge clk);
        #1;
        check("coef_err pulse", int'(coef_err), 0);
        wait_out(y, lat);
        check("MAC write result", y, exp);
        check("MAC write result const", y, 777);
        send_check(10, "after MAC write", y);
        check("table unchanged", y, 10);

        // Write and sample together in IDLE: write lands, sample refused
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'd999;
        coef_we   = 1'b1;
        coef_addr = 7'd1;
        coef_data = 16'd16384;
        #1;
        check("in_ready with coef_we", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        mcoef[1] = 16384;
        check("no accept with coef_we", int'(busy), 0);
        check("no coef_err idle write", int'(coef_err), 0);
        send_check(50, "after idle write", y);
        check("idle write landed", y, 60);

        // Out-of-range tap index
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 7'd123;
        coef_data = 16'd1234;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("coef_err addr 123", int'(coef_err), 1);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 7'd127;
        coef_data = 16'd4321;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        check("coef_err addr 127", int'(coef_err), 1);
        send_check(7, "after bad addr", y);
        check("bad addr ignored", y, 57);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 20; i++) begin
            write_coef($urandom_range(0, N - 1), int'($urandom_range(0, 65535)) - 32768);
        end
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 7) begin
                write_coef($urandom_range(0, N - 1), int'($urandom_range(0, 65535)) - 32768);
            end
            xr = int'($urandom_range(0, 65535)) - 32768;
            send_check(xr, $sformatf("rand %0d", i), y);
        end

        // Reset in the middle of the MAC sequence
        do_reset();
        write_coef(0, 16384);
        write_coef(3, 16384);
        send_check(3000, "pre-abort a", y);
        send_check(2000, "pre-abort b", y);
        accept(4000);
        repeat (60) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort out_valid", int'(out_valid), 0);
        check("abort busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 0;
        repeat (N + 5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort no output", seen, 0);
        check("abort in_ready", int'(in_ready), 1);
        check("abort busy after", int'(busy), 0);
        check("abort out_sample", int'($signed(out_sample)), 0);
        send_check(1000, "post-abort impulse", y);
        check("post-abort zero table", y, 0);
        write_coef(1, 16384);
        write_coef(3, 16384);
        send_check(0, "post-abort follow", y);
        check("post-abort zero history", y, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
